fetch_pipeline_ctrl: RTL and testbench

//  Consumer side of the hazard-unit stall interface. Owns the fetch PC, the instruction-memory request handshake,
//  the IF/ID pipeline register and a 1-entry skid buffer. Obeys pcwrite/ifid_write/hazard, applies branch

---
 rtl/fetch_pipeline_ctrl_pkg.sv | 15 +
 rtl/fetch_pipeline_ctrl_if.sv | 28 ++
 rtl/fetch_skid_buf.sv | 54 +++++
 rtl/fetch_pipeline_ctrl.sv | 168 ++++++++++++++++
 tb/tb_fetch_pipeline_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pipeline_ctrl_pkg.sv
// Shared definitions for the fetch front end: default widths, the canonical NOP and the fetch FSM states.
package fetch_pipeline_ctrl_pkg;

  localparam int          DEFAULT_XLEN      = 64;
  localparam int          DEFAULT_ILEN      = 32;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  // FETCH: the outstanding request is on the current path.
  // DROP: the outstanding request is stale and a redirect is pending.
  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_pipeline_ctrl_if.sv
// Instruction-memory fetch bus between the fetch controller (master) and imem (slave).
// Handshake: a beat transfers in the cycle where imem_req & imem_ready; imem_rdata is valid in that same
// cycle, and imem_addr stays stable while imem_req & ~imem_ready.
interface fetch_pipeline_ctrl_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [ILEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} skid buffer; catches a fetch response that arrives while decode is frozen.
module fetch_skid_buf #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               clear,
  input  logic [PC_W-1:0]    push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  output logic               full,
  output logic [PC_W-1:0]    head_pc,
  output logic [INSTR_W-1:0] head_instr
);

  logic               full_q, full_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  // clear outranks push so a flush never leaves a stale entry behind
  always_comb begin
    full_d  = full_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (push) begin
      full_d  = 1'b1;
      pc_d    = push_pc;
      instr_d = push_instr;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      full_q  <= full_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign full       = full_q;
  assign head_pc    = pc_q;
  assign head_instr = instr_q;

endmodule

// File: rtl/fetch_pipeline_ctrl.sv
// Fetch stage controller: owns the fetch PC, the imem request, the IF/ID register and the skid buffer,
// and reacts to hazard-unit stalls and branch redirects.
module fetch_pipeline_ctrl
  import fetch_pipeline_ctrl_pkg::*;
#(
  parameter int              XLEN      = DEFAULT_XLEN,
  parameter int              ILEN      = DEFAULT_ILEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [ILEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR,
  parameter int              CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pcwrite,
  input  logic                  ifid_write,
  input  logic                  hazard,
  input  logic                  branch_taken,
  input  logic [XLEN-1:0]       branch_target,
  fetch_pipeline_ctrl_if.master imem,
  output logic [XLEN-1:0]       id_pc,
  output logic [ILEN-1:0]       id_instr,
  output logic                  id_valid,
  output logic                  idex_bubble,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count,
  output logic [CNT_W-1:0]      imem_wait_cycles,
  output fetch_state_e          dbg_state
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] redirect_q, redirect_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [ILEN-1:0] id_instr_q, id_instr_d;
  logic            id_valid_q, id_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic            stall;
  logic            imem_req;
  logic            resp;
  logic [XLEN-1:0] target_aligned;
  logic            skid_push, skid_pop, skid_clear, skid_full;
  logic [XLEN-1:0] skid_pc;
  logic [ILEN-1:0] skid_instr;

  assign stall          = ~ifid_write;
  assign target_aligned = branch_target & ~XLEN'(3);
  // A full skid means decode already owes us one instruction, so no new request is issued.
  assign imem_req       = ~rst & (((state_q == FETCH) & ~skid_full) | (state_q == DROP));
  assign resp           = imem_req & imem.imem_ready;

  fetch_skid_buf #(
    .PC_W    (XLEN),
    .INSTR_W (ILEN)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (skid_push),
    .pop        (skid_pop),
    .clear      (skid_clear),
    .push_pc    (req_addr_q),
    .push_instr (imem.imem_rdata),
    .full       (skid_full),
    .head_pc    (skid_pc),
    .head_instr (skid_instr)
  );

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    redirect_d = redirect_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    skid_clear = 1'b0;

    if (branch_taken) begin
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
      skid_clear = 1'b1;
      // An unanswered request must still complete on the bus; remember where to go afterwards.
      if (imem_req & ~imem.imem_ready) begin
        state_d    = DROP;
        redirect_d = target_aligned;
      end else begin
        state_d    = FETCH;
        req_addr_d = target_aligned;
      end
    end else if (state_q == DROP) begin
      if (!stall) begin
        id_instr_d = NOP_INSTR;
        id_valid_d = 1'b0;
      end
      if (resp) begin
        state_d    = FETCH;
        req_addr_d = redirect_q;
      end
    end else if (resp) begin
      req_addr_d = req_addr_q + XLEN'(4);
      if (!stall) begin
        id_pc_d    = req_addr_q;
        id_instr_d = imem.imem_rdata;
        id_valid_d = 1'b1;
      end else begin
        skid_push = 1'b1;
      end
    end else if (!stall) begin
      if (skid_full) begin
        skid_pop   = 1'b1;
        id_pc_d    = skid_pc;
        id_instr_d = skid_instr;
        id_valid_d = 1'b1;
      end else begin
        id_instr_d = NOP_INSTR;
        id_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(stall);
    flush_cnt_d = flush_cnt_q + CNT_W'(branch_taken);
    wait_cnt_d  = wait_cnt_q + CNT_W'(imem_req & ~imem.imem_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      req_addr_q  <= RESET_PC;
      redirect_q  <= '0;
      id_pc_q     <= '0;
      id_instr_q  <= NOP_INSTR;
      id_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      redirect_q  <= redirect_d;
      id_pc_q     <= id_pc_d;
      id_instr_q  <= id_instr_d;
      id_valid_q  <= id_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // The hazard unit must freeze PC and IF/ID together.
  a_pcwrite_matches_ifid_write: assert property (@(posedge clk) disable iff (rst) pcwrite == ifid_write);

  assign imem.imem_req    = imem_req;
  assign imem.imem_addr   = req_addr_q;
  assign id_pc            = id_pc_q;
  assign id_instr         = id_instr_q;
  assign id_valid         = id_valid_q;
  assign idex_bubble      = hazard | branch_taken | ~id_valid_q;
  assign stall_cycles     = stall_cnt_q;
  assign flush_count      = flush_cnt_q;
  assign imem_wait_cycles = wait_cnt_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_fetch_pipeline_ctrl.sv
// Directed bench for fetch_pipeline_ctrl: sequential fetch, stall with skid capture, redirects, DROP, reset.
module tb_fetch_pipeline_ctrl;
  import fetch_pipeline_ctrl_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        pcwrite, ifid_write, hazard, branch_taken;
  logic [63:0] branch_target;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid, idex_bubble;
  logic [31:0] stall_cycles, flush_count, imem_wait_cycles;
  fetch_state_e dbg_state;

  int checks   = 0;
  int failures = 0;

  fetch_pipeline_ctrl_if #(.XLEN(64), .ILEN(32)) imem_bus ();

  fetch_pipeline_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .pcwrite          (pcwrite),
    .ifid_write       (ifid_write),
    .hazard           (hazard),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem             (imem_bus),
    .id_pc            (id_pc),
    .id_instr         (id_instr),
    .id_valid         (id_valid),
    .idex_bubble      (idex_bubble),
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count),
    .imem_wait_cycles (imem_wait_cycles),
    .dbg_state        (dbg_state)
  );

  // imem model: instruction word is a tag plus the low address bits
  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return 32'h1000_0000 | a[31:0];
  endfunction

  assign imem_bus.imem_rdata = instr_of(imem_bus.imem_addr);

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_stall(input logic s);
    ifid_write = ~s;
    pcwrite    = ~s;
  endtask

  initial begin
    rst = 1'b1;
    set_stall(1'b0);
    hazard = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    imem_bus.imem_ready = 1'b1;
    tick();
    tick();

    // 1: reset state, then sequential fetch
    check_val("rst_req", 64'(imem_bus.imem_req), 64'd0);
    check_val("rst_valid", 64'(id_valid), 64'd0);
    check_val("rst_instr", 64'(id_instr), 64'(NOP));
    check_val("rst_pc", id_pc, 64'h0);
    rst = 1'b0;
    #1;
    check_val("seq_addr0", imem_bus.imem_addr, 64'h0);
    check_val("seq_req0", 64'(imem_bus.imem_req), 64'd1);
    check_val("seq_valid0", 64'(id_valid), 64'd0);
    tick();
    check_val("seq_addr4", imem_bus.imem_addr, 64'h4);
    check_val("seq_idpc0", id_pc, 64'h0);
    check_val("seq_valid1", 64'(id_valid), 64'd1);
    check_val("seq_instr0", 64'(id_instr), 64'(instr_of(64'h0)));
    tick();
    tick();
    tick();
    check_val("seq_addr10", imem_bus.imem_addr, 64'h10);
    check_val("seq_idpc0c", id_pc, 64'hC);

    // 2: one-cycle stall while 0x10 returns
    set_stall(1'b1);
    hazard = 1'b1;
    #1;
    check_val("stall_bubble", 64'(idex_bubble), 64'd1);
    tick();
    set_stall(1'b0);
    hazard = 1'b0;
    #1;
    check_val("skid_req", 64'(imem_bus.imem_req), 64'd0);
    check_val("skid_idpc", id_pc, 64'hC);
    check_val("stall_cnt1", 64'(stall_cycles), 64'd1);
    tick();
    check_val("skid_pop_pc", id_pc, 64'h10);
    check_val("skid_pop_instr", 64'(id_instr), 64'(instr_of(64'h10)));
    check_val("skid_pop_addr", imem_bus.imem_addr, 64'h14);
    tick();
    check_val("after_skid_pc", id_pc, 64'h14);
    check_val("after_skid_addr", imem_bus.imem_addr, 64'h18);

    // 3: redirect with response in the same cycle
    branch_taken = 1'b1;
    branch_target = 64'h100;
    #1;
    check_val("flush_bubble", 64'(idex_bubble), 64'd1);
    tick();
    branch_taken = 1'b0;
    #1;
    check_val("redir_addr", imem_bus.imem_addr, 64'h100);
    check_val("redir_valid", 64'(id_valid), 64'd0);
    check_val("redir_invalid_bubble", 64'(idex_bubble), 64'd1);
    check_val("flush_cnt1", 64'(flush_count), 64'd1);
    branch_taken = 1'b1;
    branch_target = 64'h23;
    tick();
    branch_taken = 1'b0;
    #1;
    check_val("align_addr", imem_bus.imem_addr, 64'h20);
    check_val("flush_cnt2", 64'(flush_count), 64'd2);

    // 4: flush while waiting at 0x20 -> DROP
    imem_bus.imem_ready = 1'b0;
    branch_taken = 1'b1;
    branch_target = 64'h200;
    tick();
    branch_taken = 1'b0;
    #1;
    check_val("drop_state", 64'(dbg_state), 64'(DROP));
    check_val("drop_addr1", imem_bus.imem_addr, 64'h20);
    check_val("drop_wait1", 64'(imem_wait_cycles), 64'd1);
    tick();
    check_val("drop_addr2", imem_bus.imem_addr, 64'h20);
    tick();
    imem_bus.imem_ready = 1'b1;
    #1;
    check_val("drop_addr3", imem_bus.imem_addr, 64'h20);
    check_val("drop_req", 64'(imem_bus.imem_req), 64'd1);
    check_val("drop_wait3", 64'(imem_wait_cycles), 64'd3);
    tick();
    check_val("drop_discard_valid", 64'(id_valid), 64'd0);
    check_val("drop_new_addr", imem_bus.imem_addr, 64'h200);
    check_val("drop_exit_state", 64'(dbg_state), 64'(FETCH));
    check_val("drop_wait_final", 64'(imem_wait_cycles), 64'd3);
    check_val("flush_cnt3", 64'(flush_count), 64'd3);

    // 5: flush and stall together with a full skid
    set_stall(1'b1);
    tick();
    check_val("t5_skid_req", 64'(imem_bus.imem_req), 64'd0);
    branch_taken = 1'b1;
    branch_target = 64'h300;
    tick();
    branch_taken = 1'b0;
    set_stall(1'b0);
    #1;
    check_val("t5_valid", 64'(id_valid), 64'd0);
    check_val("t5_req", 64'(imem_bus.imem_req), 64'd1);
    check_val("t5_addr", imem_bus.imem_addr, 64'h300);
    check_val("t5_stall_cnt", 64'(stall_cycles), 64'd3);
    tick();
    check_val("t5_idpc", id_pc, 64'h300);
    check_val("t5_instr", 64'(id_instr), 64'(instr_of(64'h300)));
    check_val("t5_idvalid", 64'(id_valid), 64'd1);
    check_val("flush_cnt4", 64'(flush_count), 64'd4);

    // 6: reset while in DROP
    imem_bus.imem_ready = 1'b0;
    branch_taken = 1'b1;
    branch_target = 64'h400;
    tick();
    branch_taken = 1'b0;
    #1;
    check_val("t6_drop", 64'(dbg_state), 64'(DROP));
    rst = 1'b1;
    #1;
    check_val("t6_req_in_rst", 64'(imem_bus.imem_req), 64'd0);
    tick();
    check_val("t6_state", 64'(dbg_state), 64'(FETCH));
    check_val("t6_addr", imem_bus.imem_addr, 64'h0);
    check_val("t6_stall_cnt", 64'(stall_cycles), 64'd0);
    check_val("t6_flush_cnt", 64'(flush_count), 64'd0);
    check_val("t6_wait_cnt", 64'(imem_wait_cycles), 64'd0);
    check_val("t6_instr", 64'(id_instr), 64'(NOP));
    check_val("t6_valid", 64'(id_valid), 64'd0);
    rst = 1'b0;
    #1;
    check_val("t6_req_after", 64'(imem_bus.imem_req), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
